unified_cache_port_mux: RTL and testbench
=========================================

// Module: unified_cache_port_mux
// PURPOSE
//  N-channel request/response multiplexer in front of the memory port of the unified cache.
//  Buffers each requester in its own FIFO and stamps the packet with its channel ID.
//  Arbitrates round-robin, with full (critical) queues served first, into one to-mem packet register.
//  Routes returning memory packets to per-channel response registers by the stamped channel ID.
//  Generalises the fixed 2-channel inst/data front-end, whose routing used the type bit.
// PARAMETERS
//  NUM_CHANNELS      4   requester count; 2..2^CH_ID_WIDTH
//  CH_ID_WIDTH       2   width of channel-ID field in packet
//  PACKET_WIDTH      70  packet width in bits
//  VALID_POS         69  packet valid bit position
//  CH_ID_POS_LO      64  LSB of channel-ID field; field = [CH_ID_POS_LO +: CH_ID_WIDTH]
//  QUEUE_DEPTH       4   per-channel request FIFO entries; must equal 2^QUEUE_PTR_WIDTH
//  QUEUE_PTR_WIDTH   2   FIFO pointer width
// PORTS
//  clk_in                  in   1                         clock, rising edge
//  reset_in                in   1                         async reset, active-low
//  req_packed_in           in   NUM_CHANNELS*PACKET_WIDTH channel i at [i*PACKET_WIDTH +: PACKET_WIDTH]
//  req_ack_packed_out      out  NUM_CHANNELS              1-cycle accept pulse per channel
//  queue_full_packed_out   out  NUM_CHANNELS              per-channel FIFO full (critical)
//  to_mem_packet_out       out  PACKET_WIDTH              granted request; valid bit set when occupied
//  to_mem_packet_ack_in    in   1                         memory consumed to_mem_packet_out
//  from_mem_packet_in      in   PACKET_WIDTH              memory response; valid bit qualifies it
//  from_mem_packet_ack_out out  1                         1-cycle accept pulse for response
//  resp_packed_out         out  NUM_CHANNELS*PACKET_WIDTH per-channel response register
//  resp_ack_packed_in      in   NUM_CHANNELS              requester consumed its response
//  err_bad_ch_out          out  1                         sticky: response with ID >= NUM_CHANNELS
// BEHAVIOUR
//  Reset (reset_in=0, async):
//   - FIFOs empty; all packet outputs and acks = 0; err_bad_ch_out = 0.
//   - RR pointer = NUM_CHANNELS-1, so channel 0 wins first.
//   - All in-flight packets are discarded; no state survives a mid-operation reset.
//  Ingress, per channel i, in cycle T:
//   - Capture when packet valid bit = 1, FIFO not full and req_ack_packed_out[i] = 0.
//   - The entry is written at the end of T with the ID field overwritten by i.
//   - req_ack_packed_out[i] = 1 during T+1; input ignored in T+1; upstream updates packet after T+1.
//   - Max acceptance is 1 packet per 2 cycles per channel.
//   - A full FIFO blocks push even if a pop happens in the same cycle.
//   - Push and pop in the same cycle on a non-full FIFO are legal; the count is unchanged.
//  Full/empty and pointers:
//   - Count of 0..QUEUE_DEPTH held in QUEUE_PTR_WIDTH+1 bits.
//   - Read and write pointers wrap modulo QUEUE_DEPTH.
//   - queue_full_packed_out[i] is registered and equals (count == QUEUE_DEPTH).
//  Egress:
//   - The output register is loadable when it is empty, or when to_mem_packet_ack_in = 1 while it holds a valid packet.
//   - Candidates are the non-empty FIFOs whose queue_full bit is set; if there are none, all non-empty FIFOs.
//   - Winner = first candidate after the RR pointer, wrapping upward. The RR pointer updates to the winner.
//   - Winner's head is popped and loaded at the edge; ack plus a new candidate gives back-to-back issue.
//   - If there is no candidate at ack, the register clears to 0.
//   - to_mem_packet_ack_in is ignored while the output is invalid.
//   - Minimum latency: request valid in cycle T, on to_mem_packet_out in T+2.
//   - The packet is held stable until acked.
//  Response:
//   - from_mem_packet_in valid with ID c < NUM_CHANNELS: captured into resp slot c when the slot is empty or resp_ack_packed_in[c] = 1 that cycle.
//   - from_mem_packet_ack_out pulses the next cycle; input is ignored during the ack cycle.
//   - If slot c is busy, the response is not acked and the memory side stalls.
//   - Slot c clears (to 0) at the edge where resp_ack_packed_in[c] = 1, unless it is reloaded at that same edge.
//   - Valid response with ID >= NUM_CHANNELS: acked, dropped, err_bad_ch_out set until reset.
// TESTING
//  1. Traffic on all channels, then reset_in=0 mid-burst -> all outputs 0 immediately; first grant after release = ch0.
//  2. ch2 sends packet (ID field 0) at T -> req_ack[2] at T+1; to_mem valid at T+2 with ID=2; mem ack clears it.
//  3. ch0..3 always valid, mem ack held 1 -> grant order 0,1,2,3,0,1,... with no idle cycles on to_mem.
//  4. Mem ack 0 for 12 cycles, ch3 fills (queue_full[3]=1), ch0/ch1 one each -> on release ch3 is served first until not full, then RR.
//  5. Response ID=1 while slot 1 full, resp_ack[1]=0 for 5 cycles -> from_mem ack withheld 5 cycles; captured and acked once slot 1 frees.
//  6. NUM_CHANNELS=3, response ID=3 -> acked next cycle, no resp slot changes, err_bad_ch_out=1 sticky.

Source files
------------

// File: rtl/unified_cache_port_mux.sv
// N-channel request/response mux in front of the unified cache memory port.
// Per-channel request FIFOs stamp the channel ID; responses route back by that ID.
module unified_cache_port_mux #(
    parameter int NUM_CHANNELS    = 4,
    parameter int CH_ID_WIDTH     = 2,
    parameter int PACKET_WIDTH    = 70,
    parameter int VALID_POS       = 69,
    parameter int CH_ID_POS_LO    = 64,
    parameter int QUEUE_DEPTH     = 4,
    parameter int QUEUE_PTR_WIDTH = 2
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic [NUM_CHANNELS*PACKET_WIDTH-1:0] req_packed_in,
    output logic [NUM_CHANNELS-1:0]              req_ack_packed_out,
    output logic [NUM_CHANNELS-1:0]              queue_full_packed_out,
    output logic [PACKET_WIDTH-1:0]              to_mem_packet_out,
    input  logic                                 to_mem_packet_ack_in,
    input  logic [PACKET_WIDTH-1:0]              from_mem_packet_in,
    output logic                                 from_mem_packet_ack_out,
    output logic [NUM_CHANNELS*PACKET_WIDTH-1:0] resp_packed_out,
    input  logic [NUM_CHANNELS-1:0]              resp_ack_packed_in,
    output logic                                 err_bad_ch_out
);

    logic [NUM_CHANNELS-1:0]              w_nonempty;
    logic [NUM_CHANNELS-1:0]              w_full;
    logic [NUM_CHANNELS-1:0]              w_req_ack;
    logic [NUM_CHANNELS-1:0]              w_pop;
    logic [NUM_CHANNELS*PACKET_WIDTH-1:0] w_head_packed;

    logic [NUM_CHANNELS-1:0]              w_crit;
    logic [NUM_CHANNELS-1:0]              w_cand;
    logic                                 w_any_cand;
    logic [CH_ID_WIDTH-1:0]               w_winner;
    logic [PACKET_WIDTH-1:0]              w_win_pkt;
    logic                                 w_load_en;

    logic [PACKET_WIDTH-1:0]              r_to_mem;
    logic [CH_ID_WIDTH-1:0]               r_rr;

    logic [CH_ID_WIDTH-1:0]               w_resp_id;
    logic                                 w_from_valid;
    logic                                 w_bad_id;
    logic [NUM_CHANNELS-1:0]              w_slot_load;
    logic                                 r_from_ack;
    logic                                 r_err;

    // ------------------------------------------------------------------
    // Per-channel ingress FIFOs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        logic [PACKET_WIDTH-1:0]    r_mem [QUEUE_DEPTH];
        logic [QUEUE_PTR_WIDTH-1:0] r_wr_ptr;
        logic [QUEUE_PTR_WIDTH-1:0] r_rd_ptr;
        logic [QUEUE_PTR_WIDTH:0]   r_count;
        logic [QUEUE_PTR_WIDTH:0]   w_count_next;
        logic                       r_full;
        logic                       r_ack;
        logic                       w_push;
        logic [PACKET_WIDTH-1:0]    w_stamped;

        always_comb begin
            w_stamped = req_packed_in[gi*PACKET_WIDTH +: PACKET_WIDTH];
            w_stamped[CH_ID_POS_LO +: CH_ID_WIDTH] = CH_ID_WIDTH'(gi);
        end

        // Registered full flag gates the push, so a same-cycle pop never frees a slot early.
        assign w_push = req_packed_in[gi*PACKET_WIDTH + VALID_POS] && !r_full && !r_ack;

        always_comb begin
            w_count_next = r_count;
            case ({w_push, w_pop[gi]})
                2'b10:   w_count_next = r_count + 1'b1;
                2'b01:   w_count_next = r_count - 1'b1;
                default: w_count_next = r_count;
            endcase
        end

        always_ff @(posedge clk_in) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_stamped;
            end
        end

        always_ff @(posedge clk_in or negedge reset_in) begin
            if (!reset_in) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_full   <= 1'b0;
                r_ack    <= 1'b0;
            end else begin
                r_ack <= w_push;
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[gi]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= w_count_next;
                r_full  <= (w_count_next == (QUEUE_PTR_WIDTH+1)'(QUEUE_DEPTH));
            end
        end

        assign w_head_packed[gi*PACKET_WIDTH +: PACKET_WIDTH] = r_mem[r_rd_ptr];
        assign w_nonempty[gi] = (r_count != '0);
        assign w_full[gi]     = r_full;
        assign w_req_ack[gi]  = r_ack;
        assign w_pop[gi]      = w_load_en && w_any_cand && (w_winner == CH_ID_WIDTH'(gi));
    end

    assign req_ack_packed_out    = w_req_ack;
    assign queue_full_packed_out = w_full;

    // ------------------------------------------------------------------
    // Egress arbitration: full queues first, round-robin within the set
    // ------------------------------------------------------------------
    assign w_crit     = w_nonempty & w_full;
    assign w_cand     = (|w_crit) ? w_crit : w_nonempty;
    assign w_any_cand = |w_cand;
    assign w_load_en  = !r_to_mem[VALID_POS] || to_mem_packet_ack_in;

    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        w_winner  = '0;
        w_win_pkt = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            idx = (int'(r_rr) + k) % NUM_CHANNELS;
            if (!found && w_cand[idx]) begin
                found     = 1'b1;
                w_winner  = CH_ID_WIDTH'(idx);
                w_win_pkt = w_head_packed[idx*PACKET_WIDTH +: PACKET_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_to_mem <= '0;
            r_rr     <= CH_ID_WIDTH'(NUM_CHANNELS - 1);
        end else if (w_load_en) begin
            if (w_any_cand) begin
                r_to_mem <= w_win_pkt;
                r_rr     <= w_winner;
            end else begin
                r_to_mem <= '0;
            end
        end
    end

    assign to_mem_packet_out = r_to_mem;

    // ------------------------------------------------------------------
    // Response routing by stamped channel ID
    // ------------------------------------------------------------------
    assign w_resp_id    = from_mem_packet_in[CH_ID_POS_LO +: CH_ID_WIDTH];
    assign w_from_valid = from_mem_packet_in[VALID_POS] && !r_from_ack;
    assign w_bad_id     = ({1'b0, w_resp_id} >= (CH_ID_WIDTH+1)'(NUM_CHANNELS));

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_resp
        logic [PACKET_WIDTH-1:0] r_resp;

        assign w_slot_load[gi] = w_from_valid && !w_bad_id &&
                                 (w_resp_id == CH_ID_WIDTH'(gi)) &&
                                 (!r_resp[VALID_POS] || resp_ack_packed_in[gi]);

        always_ff @(posedge clk_in or negedge reset_in) begin
            if (!reset_in) begin
                r_resp <= '0;
            end else if (w_slot_load[gi]) begin
                r_resp <= from_mem_packet_in;
            end else if (resp_ack_packed_in[gi]) begin
                r_resp <= '0;
            end
        end

        assign resp_packed_out[gi*PACKET_WIDTH +: PACKET_WIDTH] = r_resp;
    end

    // Bad IDs are acknowledged and dropped so the memory side never wedges on them.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_from_ack <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_from_ack <= w_from_valid && (w_bad_id || (|w_slot_load));
            r_err      <= r_err || (w_from_valid && w_bad_id);
        end
    end

    assign from_mem_packet_ack_out = r_from_ack;
    assign err_bad_ch_out          = r_err;

endmodule

// File: tb/tb_unified_cache_port_mux.sv
// Directed bench for unified_cache_port_mux: a 4-channel instance plus a
// 3-channel instance used for out-of-range response IDs.
module tb_unified_cache_port_mux;

    localparam int PW = 70;

    logic clk;
    logic rst_n;

    logic [4*PW-1:0] req;
    logic [3:0]      req_ack;
    logic [3:0]      q_full;
    logic [PW-1:0]   to_mem;
    logic            to_mem_ack;
    logic [PW-1:0]   from_mem;
    logic            from_ack;
    logic [4*PW-1:0] resp;
    logic [3:0]      resp_ack;
    logic            err;

    logic [3*PW-1:0] req3;
    logic [2:0]      req_ack3;
    logic [2:0]      q_full3;
    logic [PW-1:0]   to_mem3;
    logic            to_mem_ack3;
    logic [PW-1:0]   from_mem3;
    logic            from_ack3;
    logic [3*PW-1:0] resp3;
    logic [2:0]      resp_ack3;
    logic            err3;

    int n_assert = 0;
    int n_fail   = 0;

    unified_cache_port_mux dut (
        .clk_in                 (clk),
        .reset_in               (rst_n),
        .req_packed_in          (req),
        .req_ack_packed_out     (req_ack),
        .queue_full_packed_out  (q_full),
        .to_mem_packet_out      (to_mem),
        .to_mem_packet_ack_in   (to_mem_ack),
        .from_mem_packet_in     (from_mem),
        .from_mem_packet_ack_out(from_ack),
        .resp_packed_out        (resp),
        .resp_ack_packed_in     (resp_ack),
        .err_bad_ch_out         (err)
    );

    unified_cache_port_mux #(.NUM_CHANNELS(3)) dut3 (
        .clk_in                 (clk),
        .reset_in               (rst_n),
        .req_packed_in          (req3),
        .req_ack_packed_out     (req_ack3),
        .queue_full_packed_out  (q_full3),
        .to_mem_packet_out      (to_mem3),
        .to_mem_packet_ack_in   (to_mem_ack3),
        .from_mem_packet_in     (from_mem3),
        .from_mem_packet_ack_out(from_ack3),
        .resp_packed_out        (resp3),
        .resp_ack_packed_in     (resp_ack3),
        .err_bad_ch_out         (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk(input logic v, input logic [1:0] id, input logic [63:0] d);
        return {v, 3'b000, id, d};
    endfunction

    function automatic logic [63:0] dat(input int ch);
        return 64'hC0DE_0000_0000_0000 | 64'(ch);
    endfunction

    task automatic chk(input string tag, input logic [4*PW-1:0] obs, input logic [4*PW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [PW-1:0] p);
        req[ch*PW +: PW] = p;
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = '0;
        to_mem_ack  = 1'b0;
        from_mem    = '0;
        resp_ack    = '0;
        req3        = '0;
        to_mem_ack3 = 1'b0;
        from_mem3   = '0;
        resp_ack3   = '0;

        // Reset state
        tick;
        tick;
        chk("rst_to_mem",   to_mem,   '0);
        chk("rst_req_ack",  req_ack,  '0);
        chk("rst_q_full",   q_full,   '0);
        chk("rst_from_ack", from_ack, '0);
        chk("rst_resp",     resp,     '0);
        chk("rst_err",      err,      '0);
        chk("rst_err3",     err3,     '0);
        rst_n = 1'b1;

        // All four channels streaming with mem ack held: strict RR, no bubbles
        for (int i = 0; i < 4; i++) set_req(i, mk(1'b1, 2'(3 - i), dat(i)));
        to_mem_ack = 1'b1;
        tick;
        chk("rr_first_empty", to_mem, '0);
        for (int k = 0; k < 8; k++) begin
            tick;
            chk($sformatf("rr_grant_%0d", k), to_mem, mk(1'b1, 2'(k % 4), dat(k % 4)));
        end

        // Mid-burst reset clears everything at once; channel 0 wins first afterwards
        rst_n = 1'b0;
        #1;
        chk("mid_rst_to_mem",  to_mem,  '0);
        chk("mid_rst_req_ack", req_ack, '0);
        chk("mid_rst_q_full",  q_full,  '0);
        chk("mid_rst_resp",    resp,    '0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("post_rst_req_ack", req_ack, 4'hF);
        chk("post_rst_to_mem0", to_mem,  '0);
        tick;
        chk("post_rst_grant_ch0", to_mem, mk(1'b1, 2'd0, dat(0)));
        req = '0;
        tick;
        chk("post_rst_grant_ch1", to_mem, mk(1'b1, 2'd1, dat(1)));
        repeat (3) tick;
        chk("post_rst_drained", to_mem, '0);
        to_mem_ack = 1'b0;

        // Single request on ch2 with ID field 0: stamped to 2, latency 2
        set_req(2, mk(1'b1, 2'd0, 64'hA2));
        tick;
        chk("ch2_req_ack", req_ack, 4'b0100);
        chk("ch2_t1_idle", to_mem,  '0);
        tick;
        chk("ch2_to_mem",      to_mem,  mk(1'b1, 2'd2, 64'hA2));
        chk("ch2_req_ack_off", req_ack, 4'b0000);
        req = '0;
        tick;
        chk("ch2_held", to_mem, mk(1'b1, 2'd2, 64'hA2));
        to_mem_ack = 1'b1;
        tick;
        chk("ch2_acked_clear", to_mem, '0);
        to_mem_ack = 1'b0;

        // Stall memory, fill ch3, one packet each on ch0/ch1; critical ch3 first on release
        set_req(0, mk(1'b1, 2'd3, dat(0)));
        set_req(1, mk(1'b1, 2'd3, dat(1)));
        set_req(3, mk(1'b1, 2'd0, dat(3)));
        tick;
        chk("crit_req_ack", req_ack, 4'b1011);
        tick;
        chk("crit_first_load", to_mem, mk(1'b1, 2'd3, dat(3)));
        set_req(0, '0);
        set_req(1, '0);
        repeat (7) tick;
        chk("crit_q_full3", q_full, 4'b1000);
        repeat (3) tick;
        chk("crit_hold_stable", to_mem, mk(1'b1, 2'd3, dat(3)));
        chk("crit_still_full",  q_full, 4'b1000);
        set_req(3, '0);
        to_mem_ack = 1'b1;
        tick;
        chk("crit_ch3_served", to_mem, mk(1'b1, 2'd3, dat(3)));
        chk("crit_not_full",   q_full, 4'b0000);
        tick;
        chk("crit_rr_ch0", to_mem, mk(1'b1, 2'd0, dat(0)));
        tick;
        chk("crit_rr_ch1", to_mem, mk(1'b1, 2'd1, dat(1)));
        tick;
        chk("crit_rr_ch3", to_mem, mk(1'b1, 2'd3, dat(3)));
        repeat (3) tick;
        chk("crit_drained", to_mem, '0);
        to_mem_ack = 1'b0;

        // Response to slot 1, then a second one stalls while slot 1 stays busy
        from_mem = mk(1'b1, 2'd1, 64'hB1);
        tick;
        chk("resp1_ack",  from_ack, 1'b1);
        chk("resp1_slot", resp, {mk(1'b0, 2'd0, 64'h0), mk(1'b0, 2'd0, 64'h0),
                                 mk(1'b1, 2'd1, 64'hB1), mk(1'b0, 2'd0, 64'h0)});
        from_mem = mk(1'b1, 2'd1, 64'hB2);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("resp_stall_%0d", k), from_ack, 1'b0);
        end
        chk("resp_stall_slot", resp[PW +: PW], mk(1'b1, 2'd1, 64'hB1));
        resp_ack = 4'b0010;
        tick;
        chk("resp2_ack",  from_ack, 1'b1);
        chk("resp2_slot", resp, {mk(1'b0, 2'd0, 64'h0), mk(1'b0, 2'd0, 64'h0),
                                 mk(1'b1, 2'd1, 64'hB2), mk(1'b0, 2'd0, 64'h0)});
        resp_ack = 4'b0000;
        from_mem = '0;
        tick;
        chk("resp2_ack_pulse_end", from_ack, 1'b0);
        resp_ack = 4'b0010;
        tick;
        chk("resp_slot_cleared", resp, '0);
        resp_ack = 4'b0000;

        // 3-channel instance: ID 3 is out of range
        from_mem3 = mk(1'b1, 2'd3, 64'hEE);
        tick;
        chk("bad_id_ack",   from_ack3, 1'b1);
        chk("bad_id_err",   err3,      1'b1);
        chk("bad_id_resp",  resp3,     '0);
        from_mem3 = mk(1'b1, 2'd2, 64'h33);
        tick;
        chk("bad_id_ack_gap", from_ack3, 1'b0);
        tick;
        chk("ch3_good_ack",  from_ack3, 1'b1);
        chk("ch3_good_slot", resp3, {mk(1'b1, 2'd2, 64'h33), mk(1'b0, 2'd0, 64'h0), mk(1'b0, 2'd0, 64'h0)});
        chk("bad_id_sticky", err3, 1'b1);
        chk("err4_clear",    err,  1'b0);
        from_mem3 = '0;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
